// File: rtl/vga_clk_pkg.sv
// VGA pixel clock divider: shared defaults and width helper.
// Used by the divider top and its lock counter.
package vga_clk_pkg;

  localparam int DIV_DEF  = 2;
  localparam int LOCK_DEF = 16;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_clk_lock_ctr.sv
// Saturating count of divided-clock periods since reset;
// raises locked on the tick after the count saturates.
module vga_clk_lock_ctr
  import vga_clk_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_DEF
) (
  input  logic refclk,
  input  logic rst,
  input  logic tick,
  output logic locked
);

  localparam int LW = cnt_w(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LIM = LW'(LOCK_CYCLES);

  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("LOCK_CYCLES must be >= 1");
  end

  logic [LW-1:0] cnt_q = '0;
  logic [LW-1:0] cnt_d;
  logic          lk_q  = 1'b0;
  logic          lk_d;

  always_comb begin
    cnt_d = cnt_q;
    lk_d  = lk_q;
    if (tick) begin
      if (cnt_q == LIM) lk_d = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt_q <= '0;
      lk_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lk_q  <= lk_d;
    end
  end

  assign locked = lk_q;

endmodule

// File: rtl/vga_clk_divider.sv
// Integer refclk divider producing the VGA pixel clock,
// a refclk-domain rising-edge tick and a lock indication.
module vga_clk_divider
  import vga_clk_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int LOCK_CYCLES = LOCK_DEF,
  parameter bit DUTY50_ODD  = 1'b1
) (
  input  logic refclk,
  input  logic rst,
  output logic outclk_0,
  output logic tick,
  output logic locked
);

  localparam int CW    = cnt_w(DIV);
  localparam bit ODD   = (DIV % 2) != 0;
  localparam bit SPLIT = ODD && DUTY50_ODD;
  localparam int HIGH  = !ODD       ? DIV / 2 :
                         DUTY50_ODD ? (DIV - 1) / 2 :
                                      (DIV + 1) / 2;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HI_W = CW'(HIGH);

  if (DIV < 2) begin : g_bad_div
    $error("DIV must be >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("LOCK_CYCLES must be >= 1");
  end

  // cnt starts at DIV-1 so the first released edge wraps and rises
  logic [CW-1:0] cnt_q  = LAST;
  logic [CW-1:0] cnt_d;
  logic          a_q    = 1'b0;
  logic          a_d;
  logic          tick_q = 1'b0;
  logic          tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    a_d    = cnt_d < HI_W;
    tick_d = cnt_d == '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt_q  <= LAST;
      a_q    <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      tick_q <= tick_d;
    end
  end

  // half-cycle stretch of a gives 50% duty for odd ratios
  if (SPLIT) begin : g_split
    logic b_q = 1'b0;
    always_ff @(negedge refclk) b_q <= a_q;
    assign outclk_0 = a_q | b_q;
  end else begin : g_plain
    assign outclk_0 = a_q;
  end

  assign tick = tick_q;

  vga_clk_lock_ctr #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock (
    .refclk(refclk),
    .rst   (rst),
    .tick  (tick_d),
    .locked(locked)
  );

endmodule

// File: tb/tb_vga_clk_divider.sv
// Randomized reset stress of several divider configurations
// against a waveform-level model of the divided clock.
module tb_vga_clk_divider;

  logic       refclk = 1'b0;
  logic [5:0] rst;
  logic [5:0] oc;
  logic [5:0] tk;
  logic [5:0] lk;

  int total = 0;
  int bad   = 0;

  always #5 refclk = ~refclk;

  vga_clk_divider #(.DIV(2), .LOCK_CYCLES(16), .DUTY50_ODD(1'b1)) u0 (
    .refclk(refclk), .rst(rst[0]), .outclk_0(oc[0]), .tick(tk[0]), .locked(lk[0]));
  vga_clk_divider #(.DIV(3), .LOCK_CYCLES(4), .DUTY50_ODD(1'b1)) u1 (
    .refclk(refclk), .rst(rst[1]), .outclk_0(oc[1]), .tick(tk[1]), .locked(lk[1]));
  vga_clk_divider #(.DIV(3), .LOCK_CYCLES(3), .DUTY50_ODD(1'b0)) u2 (
    .refclk(refclk), .rst(rst[2]), .outclk_0(oc[2]), .tick(tk[2]), .locked(lk[2]));
  vga_clk_divider #(.DIV(4), .LOCK_CYCLES(2), .DUTY50_ODD(1'b1)) u3 (
    .refclk(refclk), .rst(rst[3]), .outclk_0(oc[3]), .tick(tk[3]), .locked(lk[3]));
  vga_clk_divider #(.DIV(6), .LOCK_CYCLES(5), .DUTY50_ODD(1'b1)) u4 (
    .refclk(refclk), .rst(rst[4]), .outclk_0(oc[4]), .tick(tk[4]), .locked(lk[4]));
  vga_clk_divider #(.DIV(5), .LOCK_CYCLES(1), .DUTY50_ODD(1'b1)) u5 (
    .refclk(refclk), .rst(rst[5]), .outclk_0(oc[5]), .tick(tk[5]), .locked(lk[5]));

  function automatic int p_div(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 3;
      3: return 4;
      4: return 6;
      default: return 5;
    endcase
  endfunction

  function automatic int p_lock(input int i);
    case (i)
      0: return 16;
      1: return 4;
      2: return 3;
      3: return 2;
      4: return 5;
      default: return 1;
    endcase
  endfunction

  function automatic bit p_half(input int i);
    return (p_div(i) % 2 == 1) && (i != 2);
  endfunction

  // whole refclk phases outclk spends high at the start of a period
  function automatic int full_hi(input int i);
    int d;
    d = p_div(i);
    if (d % 2 == 0) return d / 2;
    if (i == 2) return (d + 1) / 2;
    return (d - 1) / 2;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int n    [6];
  int hold [6];
  bit hi   [6];
  bit prev [6];

  initial begin
    int p;
    int ticks;
    bit e_oc;
    rst = '1;
    for (int i = 0; i < 6; i++) begin
      n[i] = 0;
      hold[i] = 2;
      prev[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("pwr_oc%0d", i), int'(oc[i]), 0);
      chk($sformatf("pwr_tk%0d", i), int'(tk[i]), 0);
      chk($sformatf("pwr_lk%0d", i), int'(lk[i]), 0);
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge refclk);
      for (int i = 0; i < 6; i++)
        n[i] = rst[i] ? 0 : n[i] + 1;
      #1;
      for (int i = 0; i < 6; i++) begin
        p = (n[i] > 0) ? (n[i] - 1) % p_div(i) : 0;
        ticks = (n[i] > 0) ? (n[i] - 1) / p_div(i) + 1 : 0;
        hi[i] = (n[i] > 0) && (p < full_hi(i));
        e_oc = hi[i] || (p_half(i) && prev[i]);
        chk($sformatf("oc1_%0d c%0d", i, cyc), int'(oc[i]), int'(e_oc));
        chk($sformatf("tk%0d c%0d", i, cyc), int'(tk[i]),
            int'((n[i] > 0) && (p == 0)));
        chk($sformatf("lk%0d c%0d", i, cyc), int'(lk[i]),
            int'(ticks > p_lock(i)));
      end
      @(negedge refclk);
      #1;
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("oc2_%0d c%0d", i, cyc), int'(oc[i]), int'(hi[i]));
        prev[i] = hi[i];
      end
      #1;
      for (int i = 0; i < 6; i++) begin
        if (hold[i] == 0 && $urandom_range(0, 59) == 0)
          hold[i] = $urandom_range(1, 12);
        rst[i] = (hold[i] != 0);
        if (hold[i] != 0) hold[i]--;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
